// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises 24-bit GRB pixels (MSB first) into the WS2812 one-wire
// NRZ waveform. Every bit lasts BIT_CYCLES clocks. The line is high for
// T1H_CYCLES clocks on a '1' bit and for T0H_CYCLES clocks on a '0' bit. A pixel
// flagged last is followed by LATCH_CYCLES clocks of low line.
//
// Ports
//   clk          in   1   pixel clock, all logic on rising edge
//   resetn       in   1   synchronous, active-low reset
//   pixel_data   in   24  {G,R,B}, bit 23 sent first
//   pixel_last   in   1   last pixel of frame, latch period follows
//   pixel_valid  in   1   pixel_data/pixel_last valid
//   pixel_ready  out  1   combinational accept (valid & ready = transfer)
//   dout         out  1   registered WS2812 data line
//   busy         out  1   registered, high whenever the block is not idle
module ws2812_tx #(
  parameter int unsigned T0H_CYCLES   = 13,
  parameter int unsigned T1H_CYCLES   = 27,
  parameter int unsigned BIT_CYCLES   = 42,
  parameter int unsigned LATCH_CYCLES = 1700
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [23:0] pixel_data,
  input  logic        pixel_last,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        dout,
  output logic        busy
);

  localparam int unsigned PW         = 24;
  localparam int unsigned IW         = 5;
  localparam int unsigned MAX_CYCLES = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES);

  // Reject timing parameters that cannot produce a valid waveform.
  if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) &&
        (T1H_CYCLES < BIT_CYCLES) && (LATCH_CYCLES >= 1))) begin : g_bad_params
    $error("ws2812_tx: illegal timing parameters");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   shreg;
  logic            cur_last;
  logic [IW-1:0]   bit_idx;
  logic [CW-1:0]   cyc;
  logic [CW-1:0]   high_cycles;
  logic            bit_end;
  logic            pixel_end;
  logic            latch_end;
  logic            xfer;
  logic            dout_nxt;

  assign bit_end   = (cyc == CW'(BIT_CYCLES - 1));
  assign pixel_end = (state == ST_SEND) && bit_end && (bit_idx == '0);
  assign latch_end = (state == ST_LATCH) && (cyc == CW'(LATCH_CYCLES - 1));
  assign xfer      = pixel_valid & pixel_ready;

  // Current bit always sits at the top of the shift register.
  assign high_cycles = shreg[PW-1] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
  assign dout_nxt    = (state == ST_SEND) && (cyc < high_cycles);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a pixel end with a waiting pixel stays in SEND (zero gap).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (pixel_end) begin
          if (cur_last)   state_nxt = ST_LATCH;
          else if (!xfer) state_nxt = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (latch_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ready depends only on state/counters so valid can safely wait on it.
  always_comb begin
    pixel_ready = 1'b0;
    if (resetn) begin
      case (state)
        ST_IDLE: pixel_ready = 1'b1;
        ST_SEND: pixel_ready = pixel_end && !cur_last;
        default: pixel_ready = 1'b0;
      endcase
    end
  end

  // Datapath: shift register, bit index, cycle counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shreg    <= '0;
      cur_last <= 1'b0;
      bit_idx  <= '0;
      cyc      <= '0;
      dout     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      dout <= dout_nxt;
      busy <= (state_nxt != ST_IDLE);
      if (xfer) begin
        shreg    <= pixel_data;
        cur_last <= pixel_last;
        bit_idx  <= IW'(PW - 1);
        cyc      <= '0;
      end else begin
        case (state)
          ST_SEND: begin
            if (bit_end) begin
              cyc <= '0;
              if (bit_idx != '0) begin
                bit_idx <= bit_idx - IW'(1);
                shreg   <= {shreg[PW-2:0], 1'b0};
              end
            end else begin
              cyc <= cyc + CW'(1);
            end
          end
          ST_LATCH: begin
            if (latch_end) cyc <= '0;
            else           cyc <= cyc + CW'(1);
          end
          default: cyc <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a timeline model of the waveform.
module tb_ws2812_tx;

  localparam int T0H   = 13;
  localparam int T1H   = 27;
  localparam int BITC  = 42;
  localparam int LATCH = 1700;
  localparam int PIX   = 24 * BITC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        pixel_last = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic        dout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ws2812_tx dut (
    .clk         (clk),
    .resetn      (resetn),
    .pixel_data  (pixel_data),
    .pixel_last  (pixel_last),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .dout        (dout),
    .busy        (busy)
  );

  always #15 clk = ~clk;

  initial begin
    #(30 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: kind 0 idle, 1 sending a pixel transferred at edge m_start,
  // 2 latching until edge m_latch_end. The waveform is derived from elapsed time.
  int unsigned e = 0;
  int          m_kind = 0;
  int unsigned m_start = 0;
  int unsigned m_latch_end = 0;
  logic [23:0] m_data = '0;
  logic        m_last = 1'b0;
  logic        exp_dout = 1'b0;
  logic        exp_busy = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    int unsigned el;
    logic rdy;
    logic xf;
    e = e + 1;
    rdy = resetn && (m_kind == 0 || (m_kind == 1 && (e - m_start) == PIX && !m_last));
    xf  = pixel_valid && rdy;
    exp_dout = 1'b0;
    if (resetn && m_kind == 1) begin
      el = e - m_start - 1;
      exp_dout = ((el % BITC) < (m_data[23 - el / BITC] ? T1H : T0H));
    end
    if (!resetn) begin
      m_kind = 0;
      chk_en = 1'b1;
    end else begin
      case (m_kind)
        0: if (xf) begin
          m_kind = 1; m_start = e; m_data = pixel_data; m_last = pixel_last;
        end
        1: if ((e - m_start) == PIX) begin
          if (m_last) begin
            m_kind = 2; m_latch_end = e + LATCH;
          end else if (xf) begin
            m_start = e; m_data = pixel_data; m_last = pixel_last;
          end else begin
            m_kind = 0;
          end
        end
        default: if (e == m_latch_end) m_kind = 0;
      endcase
    end
    exp_busy = (m_kind != 0);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_ready;
    if (chk_en) begin
      exp_ready = resetn && (m_kind == 0 ||
                  (m_kind == 1 && (e + 1 - m_start) == PIX && !m_last));
      checks += 3;
      if (dout !== exp_dout) begin
        errors++;
        if (errors <= 40) $display("FAIL cyc_dout edge %0d: got %b expected %b", e, dout, exp_dout);
      end
      if (busy !== exp_busy) begin
        errors++;
        if (errors <= 40) $display("FAIL cyc_busy edge %0d: got %b expected %b", e, busy, exp_busy);
      end
      if (pixel_ready !== exp_ready) begin
        errors++;
        if (errors <= 40) $display("FAIL cyc_ready edge %0d: got %b expected %b", e, pixel_ready, exp_ready);
      end
    end
  end

  task automatic wait_idle(input int limit);
    bit done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    chk("wait_idle", 32'(done), 32'd1);
  endtask

  initial begin
    int h23, hmid, h0, hl, hall, rc;

    // Reset held with a pending pixel; it must not transfer until release.
    resetn = 1'b0; pixel_valid = 1'b1; pixel_data = 24'h800001; pixel_last = 1'b1;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_ready", 32'(pixel_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #2 resetn = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(pixel_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    // Single pixel 0x800001, last: transfer happens on the first released edge.
    @(posedge clk); #2 pixel_valid = 1'b0;
    @(negedge clk);
    chk("p1_busy0", 32'(busy), 32'd1);
    chk("p1_dout0", 32'(dout), 32'd0);
    h23 = 0; hmid = 0; h0 = 0; hl = 0;
    for (int i = 1; i <= PIX + LATCH; i++) begin
      @(posedge clk); @(negedge clk);
      if (i <= BITC) h23 += int'(dout);
      else if (i <= 23 * BITC) hmid += int'(dout);
      else if (i <= PIX) h0 += int'(dout);
      else hl += int'(dout);
      if (i == 1)    chk("p1_rise", 32'(dout), 32'd1);
      if (i == 27)   chk("p1_hi27", 32'(dout), 32'd1);
      if (i == 28)   chk("p1_lo28", 32'(dout), 32'd0);
      if (i == 1007) chk("p1_noready", 32'(pixel_ready), 32'd0);
      if (i == 2707) chk("p1_busy_hold", 32'(busy), 32'd1);
      if (i == 2708) chk("p1_busy_fall", 32'(busy), 32'd0);
    end
    chk("p1_h23", 32'(h23), 32'd27);
    chk("p1_hmid", 32'(hmid), 32'd286);
    chk("p1_h0", 32'(h0), 32'd27);
    chk("p1_latch_low", 32'(hl), 32'd0);

    // Two pixels back to back with valid held.
    @(posedge clk); #2 pixel_valid = 1'b1; pixel_data = 24'hA5A5A5; pixel_last = 1'b0;
    @(posedge clk); #2 pixel_data = 24'hC0FFEE; pixel_last = 1'b1;
    for (int i = 1; i <= 1009; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 1)    chk("b2b_rise1", 32'(dout), 32'd1);
      if (i == 1006) chk("b2b_ready_pre", 32'(pixel_ready), 32'd0);
      if (i == 1007) chk("b2b_ready_pulse", 32'(pixel_ready), 32'd1);
      if (i == 1008) chk("b2b_ready_post", 32'(pixel_ready), 32'd0);
      if (i == 1008) chk("b2b_gap_low", 32'(dout), 32'd0);
      if (i == 1009) chk("b2b_rise2", 32'(dout), 32'd1);
      if (i == 1008) pixel_valid = 1'b0;
    end
    wait_idle(4000);

    // Underrun: all-ones pixel, not last, nothing follows.
    @(posedge clk); #2 pixel_valid = 1'b1; pixel_data = 24'hFFFFFF; pixel_last = 1'b0;
    @(posedge clk); #2 pixel_valid = 1'b0;
    hall = 0;
    for (int i = 1; i <= 1010; i++) begin
      @(posedge clk); @(negedge clk);
      if (i <= PIX) hall += int'(dout);
      if (i == 1007) chk("ur_busy_hold", 32'(busy), 32'd1);
      if (i == 1008) chk("ur_busy_fall", 32'(busy), 32'd0);
      if (i == 1008) chk("ur_ready", 32'(pixel_ready), 32'd1);
      if (i == 1010) chk("ur_dout_low", 32'(dout), 32'd0);
    end
    chk("ur_highs", 32'(hall), 32'd648);

    // Reset during bit 10, then a fresh pixel.
    @(posedge clk); #2 pixel_valid = 1'b1; pixel_data = 24'($urandom); pixel_last = 1'b1;
    @(posedge clk); #2 pixel_valid = 1'b0;
    for (int i = 1; i <= 559; i++) begin
      @(posedge clk); @(negedge clk);
    end
    resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #2 resetn = 1'b1;
    pixel_valid = 1'b1; pixel_data = 24'($urandom) | 24'h800000; pixel_last = 1'b1;
    @(posedge clk); #2 pixel_valid = 1'b0;
    for (int i = 1; i <= 28; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 1)  chk("post_rst_rise", 32'(dout), 32'd1);
      if (i == 28) chk("post_rst_fall", 32'(dout), 32'd0);
    end
    wait_idle(4000);

    // Valid held through the latch period.
    @(posedge clk); #2 pixel_valid = 1'b1; pixel_data = 24'h000000; pixel_last = 1'b1;
    @(posedge clk);
    rc = 0;
    for (int i = 1; i <= PIX + LATCH + 1; i++) begin
      @(posedge clk); @(negedge clk);
      if (i <= PIX + LATCH - 1) rc += int'(pixel_ready);
      if (i == PIX + LATCH) chk("lv_ready_idle", 32'(pixel_ready), 32'd1);
      if (i == PIX + LATCH) chk("lv_busy_idle", 32'(busy), 32'd0);
      if (i == PIX + LATCH + 1) chk("lv_retransfer", 32'(busy), 32'd1);
    end
    pixel_valid = 1'b0;
    chk("lv_ready_count", 32'(rc), 32'd0);
    wait_idle(4000);

    // Randomized traffic with occasional one-cycle resets.
    for (int c = 0; c < 30000; c++) begin
      @(posedge clk); #2;
      pixel_valid = ($urandom % 4) != 0;
      pixel_data  = 24'($urandom);
      pixel_last  = ($urandom % 3) == 0;
      resetn      = ($urandom_range(0, 9999) != 0);
    end
    @(posedge clk); #2 pixel_valid = 1'b0; resetn = 1'b1;
    wait_idle(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
